// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI APB register port: requester FSM state
// encodings and the SPI register map used by both the APB master bridge and
// the SPI APB slave.
package spi_apb_pkg;

  // APB requester FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  // SPI register map
  localparam logic [2:0] CR1 = 3'b000;
  localparam logic [2:0] CR2 = 3'b001;
  localparam logic [2:0] BR  = 3'b010;
  localparam logic [2:0] SR  = 3'b011;
  localparam logic [2:0] DR  = 3'b101;

endpackage

// File: rtl/apb_master_bridge.sv
// APB requester: turns each accepted valid/ready command into one APB
// SETUP + ACCESS transfer, waits on PREADY with an optional bounded wait, and
// reports read data / error status on a one-cycle response strobe.
//
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata   command channel (host side)
//   rsp_valid/rdata/err/timeout  registered response strobe and status
//   busy                         transfer in progress (state != IDLE)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request (registered)
//   PRDATA, PREADY, PSLVERR      APB completer response
module apb_master_bridge
  import spi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Wait counter sized to hold TIMEOUT, at least one bit wide
  localparam int unsigned CNT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              busy_q, busy_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              load_cmd;

  // Next-state, command capture and response generation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_ready     = 1'b0;
    load_cmd      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load_cmd = 1'b1;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end

      ACCESS: begin
        if (PREADY) begin
          // Completion wins over a coincident timeout
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          cmd_ready     = 1'b1;
          if (cmd_valid) begin
            load_cmd = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // Abort: no back-to-back accept in this cycle
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (load_cmd) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end

    // APB controls are registered decodes of the next state
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      busy_q        <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      busy_q        <= busy_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that drives the SPI core's APB register port from a simple valid/ready command interface. It turns each accepted command into one APB SETUP + ACCESS transfer and waits on PREADY, with a bounded wait. It returns read data and error status on a single-cycle response strobe. It sits between a host/sequencer (CPU shim, test sequencer) and the SPI block's APB slave.

## Interface
Parameters:
- ADDR_W, 3, PADDR width
- DATA_W, 8, PWDATA/PRDATA width
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables timeout

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset (single clock domain)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response strobe, no backpressure
- rsp_rdata  out  DATA_W  read data, 0 for writes and timeouts
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  state != IDLE
- PSEL, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_W; PWDATA  out  DATA_W
- PRDATA  in  DATA_W; PREADY, PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0, cmd_ready=1.
  - On accept: register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA; go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - Always exactly one cycle; then go to ACCESS and clear the wait counter.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=1 completes the transfer.
  - On completion, capture PRDATA (reads only, else 0) and PSLVERR.
  - On completion, cmd_ready=1 in the same cycle.
    - If cmd_valid: back-to-back, load the new command and go to SETUP. PSEL stays 1 and PENABLE drops to 0.
    - Else: go to IDLE.
  - PREADY=0: increment the wait counter.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT-1, abort.
    - Abort sets rsp_err=1, rsp_timeout=1, rsp_rdata=0, and goes to IDLE. No back-to-back accept on abort; cmd_ready=0 in that cycle.
- Completion and abort are the only cycles outside IDLE with cmd_ready=1 (completion only).
- PADDR, PWDATA and PWRITE hold their last values in IDLE and change only on command accept.
- Wait counter width: $clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.
- PSLVERR is sampled only in the PREADY cycle; it is ignored otherwise.
- Simultaneous PREADY and timeout: PREADY wins, so the transfer completes normally with rsp_timeout=0.

## Timing
- Reset values: state=IDLE, all outputs 0 except cmd_ready=1; the counter is cleared.
- Reset mid-transfer: on the next edge PSEL=PENABLE=0, state=IDLE, and no rsp_valid for the killed transfer.
- Latency: command accepted at edge N.
  - SETUP in cycle N+1, ACCESS in cycle N+2.
  - With zero wait states (PREADY=1 in the first ACCESS cycle), rsp_valid is high in cycle N+3 for exactly one cycle.
- Each wait state adds one cycle.
- rsp_rdata, rsp_err and rsp_timeout are registered.
  - They are valid only while rsp_valid=1.
  - They hold their values until the next response.
- Back-to-back throughput: one transfer every 2 cycles with zero wait states.
- Timeout: with PREADY stuck at 0, rsp_valid rises TIMEOUT cycles after the first ACCESS cycle.

## Structure
- Shared package spi_apb_pkg holds:
  - FSM state encodings: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - SPI register address constants: CR1=3'b000, CR2=3'b001, BR=3'b010, SR=3'b011, DR=3'b101.
  - The APB slave also uses these constants.
- Single module. The wait counter is inline, with no sub-module.

## Test plan
- Write, zero wait: cmd write addr 3'b000, data 8'h5C, PREADY tied high.
  - Response: PSEL high for 2 cycles, PENABLE only in the 2nd.
  - rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: read addr 3'b101, PRDATA=8'hA7, PREADY asserted on the 3rd ACCESS cycle.
  - Response: rsp_valid at N+5, rsp_rdata=8'hA7.
- Back-to-back: three writes (addr 0/1/2, data 8'h11/8'h22/8'h33) with cmd_valid held high.
  - Response: PSEL continuously 1 and PENABLE toggling 0,1,0,1,0,1.
  - Three rsp_valid pulses, 2 cycles apart.
- Slave error: write with PSLVERR=1 in the PREADY cycle.
  - Response: rsp_err=1, rsp_timeout=0.
  - PSLVERR=1 while PREADY=0 must not set rsp_err.
- Timeout: TIMEOUT=4, PREADY stuck at 0.
  - Response: abort after 4 ACCESS cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0, and cmd_ready=0 in the abort cycle.
  - Repeat with PREADY rising in the 4th cycle: normal completion with rsp_timeout=0.
- Reset mid-ACCESS: assert PRESET for 1 cycle during a wait state.
  - Response: PSEL=PENABLE=0 at the next edge, no rsp_valid, cmd_ready=1.
